// File: rtl/nts_rx_buffer_pkg.sv
// Shared types and constants for the NTS receive buffer.
// Imported by the interface, RAM and top-level buffer.
package nts_rx_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DISCARD = 2'd2,
        ST_FULL    = 2'd3
    } state_e;

    localparam int CNT_W          = 32;
    localparam int BYTES_PER_WORD = 8;
    localparam int DATA_W         = 8 * BYTES_PER_WORD;

endpackage

// File: rtl/nts_rx_buffer_if.sv
// Frame bus from the RX preprocessor into the NTS receive buffer.
interface nts_rx_buffer_if;
    import nts_rx_buffer_pkg::*;

    logic [DATA_W-1:0] rx_data_be;
    logic [3:0]        rx_valid4bit;
    logic              sof;
    logic              packet_nts;
    logic              packet_other;
    logic              packet_drop;
    logic              ethernet_good;
    logic              ethernet_bad;

    modport master (
        output rx_data_be, rx_valid4bit, sof,
        output packet_nts, packet_other, packet_drop,
        output ethernet_good, ethernet_bad
    );

    modport slave (
        input rx_data_be, rx_valid4bit, sof,
        input packet_nts, packet_other, packet_drop,
        input ethernet_good, ethernet_bad
    );

endinterface

// File: rtl/nts_rx_bram.sv
// Simple dual-port frame RAM: one write port, one registered read port.
module nts_rx_bram
    import nts_rx_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_W-1:0]     rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Contents survive reset; only the output register is cleared.
    always_ff @(posedge clk_i) begin
        if (rst_i) rdata_q <= '0;
        else       rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/nts_rx_buffer.sv
// Single-frame capture buffer for NTS frames between the RX
// preprocessor and the NTS engine, with commit/release and stats.
module nts_rx_buffer
    import nts_rx_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_areset,
    nts_rx_buffer_if.slave        rx,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_W-1:0]     o_rd_data,
    output logic                  o_packet_available,
    output logic [ADDR_WIDTH+3:0] o_packet_length,
    input  logic                  i_release,
    output logic [CNT_W-1:0]      o_cnt_nts_ok,
    output logic [CNT_W-1:0]      o_cnt_bad,
    output logic [CNT_W-1:0]      o_cnt_overflow,
    output logic [CNT_W-1:0]      o_cnt_busy,
    output logic [CNT_W-1:0]      o_cnt_drop
);

    localparam int LEN_W = ADDR_WIDTH + 4;
    localparam int WA_W  = ADDR_WIDTH + 1;

    state_e           state_q;
    logic [WA_W-1:0]  waddr_q;
    logic [LEN_W-1:0] acc_q;
    logic [LEN_W-1:0] len_q;
    logic             avail_q;
    logic [CNT_W-1:0] ok_q, bad_q, ovf_q, busy_q, drop_q;

    logic                  has_data;
    logic                  is_nts;
    logic                  go_start;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [LEN_W-1:0]      acc_sum;
    state_e                start_state;

    // A frame flagged both NTS and other is treated as not NTS.
    assign is_nts      = rx.packet_nts & ~rx.packet_other;
    assign has_data    = rx.rx_valid4bit != 4'd0;
    assign acc_sum     = acc_q + LEN_W'(rx.rx_valid4bit);
    assign go_start    = rx.sof & ((state_q != ST_FULL) | i_release);
    assign start_state = is_nts ? ST_CAPTURE : ST_DISCARD;

    assign wr_en   = has_data & (go_start ? is_nts :
                     (state_q == ST_CAPTURE) & ~waddr_q[ADDR_WIDTH]);
    assign wr_addr = go_start ? '0 : waddr_q[ADDR_WIDTH-1:0];

    always_ff @(posedge i_clk) begin
        if (i_areset) begin
            state_q <= ST_IDLE;
            waddr_q <= '0;
            acc_q   <= '0;
            len_q   <= '0;
            avail_q <= 1'b0;
            ok_q    <= '0;
            bad_q   <= '0;
            ovf_q   <= '0;
            busy_q  <= '0;
            drop_q  <= '0;
        end else begin
            if (rx.sof & rx.packet_drop) drop_q <= drop_q + CNT_W'(1);
            // A new start of frame abandons any frame in progress.
            if (go_start) begin
                state_q <= start_state;
                waddr_q <= WA_W'(has_data);
                acc_q   <= LEN_W'(rx.rx_valid4bit);
                avail_q <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                    end
                    ST_DISCARD: begin
                        if (rx.ethernet_good | rx.ethernet_bad)
                            state_q <= ST_IDLE;
                    end
                    ST_CAPTURE: begin
                        if (rx.ethernet_bad) begin
                            bad_q   <= bad_q + CNT_W'(1);
                            state_q <= ST_IDLE;
                        end else if (has_data & waddr_q[ADDR_WIDTH]) begin
                            ovf_q   <= ovf_q + CNT_W'(1);
                            state_q <= rx.ethernet_good ? ST_IDLE : ST_DISCARD;
                        end else begin
                            if (has_data) waddr_q <= waddr_q + WA_W'(1);
                            acc_q <= acc_sum;
                            if (rx.ethernet_good) begin
                                len_q   <= acc_sum;
                                avail_q <= 1'b1;
                                ok_q    <= ok_q + CNT_W'(1);
                                state_q <= ST_FULL;
                            end
                        end
                    end
                    ST_FULL: begin
                        if (i_release) begin
                            avail_q <= 1'b0;
                            state_q <= ST_IDLE;
                        end else if (rx.sof & is_nts) begin
                            busy_q <= busy_q + CNT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    nts_rx_bram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bram (
        .clk_i   (i_clk),
        .rst_i   (i_areset),
        .we_i    (wr_en),
        .waddr_i (wr_addr),
        .wdata_i (rx.rx_data_be),
        .raddr_i (i_rd_addr),
        .rdata_o (o_rd_data)
    );

    assign o_packet_available = avail_q;
    assign o_packet_length    = len_q;
    assign o_cnt_nts_ok       = ok_q;
    assign o_cnt_bad          = bad_q;
    assign o_cnt_overflow     = ovf_q;
    assign o_cnt_busy         = busy_q;
    assign o_cnt_drop         = drop_q;

endmodule

// File: tb/tb_nts_rx_buffer.sv
// Directed scoreboard bench for nts_rx_buffer (depth 256 and depth 16).
module tb_nts_rx_buffer;
    import nts_rx_buffer_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel;
    logic [63:0] d_data;
    logic [3:0]  d_valid;
    logic        d_sof, d_nts, d_oth, d_drp, d_good, d_bad, d_rel;
    logic [7:0]  d_addr;

    nts_rx_buffer_if bus8 ();
    nts_rx_buffer_if bus4 ();

    assign bus8.rx_data_be    = sel ? '0 : d_data;
    assign bus8.rx_valid4bit  = sel ? '0 : d_valid;
    assign bus8.sof           = ~sel & d_sof;
    assign bus8.packet_nts    = ~sel & d_nts;
    assign bus8.packet_other  = ~sel & d_oth;
    assign bus8.packet_drop   = ~sel & d_drp;
    assign bus8.ethernet_good = ~sel & d_good;
    assign bus8.ethernet_bad  = ~sel & d_bad;

    assign bus4.rx_data_be    = sel ? d_data : '0;
    assign bus4.rx_valid4bit  = sel ? d_valid : '0;
    assign bus4.sof           = sel & d_sof;
    assign bus4.packet_nts    = sel & d_nts;
    assign bus4.packet_other  = sel & d_oth;
    assign bus4.packet_drop   = sel & d_drp;
    assign bus4.ethernet_good = sel & d_good;
    assign bus4.ethernet_bad  = sel & d_bad;

    logic [63:0] rd8, rd4;
    logic        av8, av4;
    logic [11:0] len8;
    logic [7:0]  len4;
    logic [31:0] ok8, bd8, ovf8, busy8, drop8;
    logic [31:0] ok4, bd4, ovf4, busy4, drop4;

    nts_rx_buffer #(.ADDR_WIDTH(8)) dut (
        .i_clk              (clk),
        .i_areset           (rst),
        .rx                 (bus8),
        .i_rd_addr          (d_addr),
        .o_rd_data          (rd8),
        .o_packet_available (av8),
        .o_packet_length    (len8),
        .i_release          (~sel & d_rel),
        .o_cnt_nts_ok       (ok8),
        .o_cnt_bad          (bd8),
        .o_cnt_overflow     (ovf8),
        .o_cnt_busy         (busy8),
        .o_cnt_drop         (drop8)
    );

    nts_rx_buffer #(.ADDR_WIDTH(4)) dut4 (
        .i_clk              (clk),
        .i_areset           (rst),
        .rx                 (bus4),
        .i_rd_addr          (d_addr[3:0]),
        .o_rd_data          (rd4),
        .o_packet_available (av4),
        .o_packet_length    (len4),
        .i_release          (sel & d_rel),
        .o_cnt_nts_ok       (ok4),
        .o_cnt_bad          (bd4),
        .o_cnt_overflow     (ovf4),
        .o_cnt_busy         (busy4),
        .o_cnt_drop         (drop4)
    );

    int total = 0;
    int nbad  = 0;
    int e_ok, e_bad, e_ovf, e_busy, e_drop;
    logic [63:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            nbad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_ok"},   64'(ok8),   64'(e_ok));
        chk({tag, "_bad"},  64'(bd8),   64'(e_bad));
        chk({tag, "_ovf"},  64'(ovf8),  64'(e_ovf));
        chk({tag, "_busy"}, 64'(busy8), 64'(e_busy));
        chk({tag, "_drop"}, 64'(drop8), 64'(e_drop));
    endtask

    task automatic idle_inputs();
        d_data = '0; d_valid = '0; d_sof = 0; d_nts = 0; d_oth = 0;
        d_drp = 0; d_good = 0; d_bad = 0; d_rel = 0;
    endtask

    function automatic logic [63:0] word_of(input logic [7:0] seed,
                                            input int k, input int nb);
        logic [63:0] w;
        logic [63:0] m;
        w = {seed, 8'(k), 48'h1122_3344_5566} ^ {8'h00, 8'h00, 8'(k * 7), 40'h0};
        m = '1;
        m = m << (8 * (8 - nb));
        return w & m;
    endfunction

    task automatic send_frame(input int nw, input int lastb, input bit nts,
                              input bit oth, input bit drp, input bit good,
                              input bit badm, input bit rel,
                              input logic [7:0] seed, input bit push);
        for (int k = 0; k < nw; k++) begin
            int nb;
            logic [63:0] w;
            nb = (k == nw - 1) ? lastb : 8;
            w = word_of(seed, k, nb);
            d_data  = w;
            d_valid = 4'(nb);
            d_sof   = (k == 0);
            d_nts   = (k == 0) & nts;
            d_oth   = (k == 0) & oth;
            d_drp   = (k == 0) & drp;
            d_rel   = (k == 0) & rel;
            d_good  = (k == nw - 1) & good;
            d_bad   = (k == nw - 1) & badm;
            if (push) exp_q.push_back(w);
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    task automatic read_back(input string tag);
        int i = 0;
        while (exp_q.size() > 0) begin
            d_addr = 8'(i);
            @(posedge clk); #1;
            chk(tag, sel ? rd4 : rd8, exp_q.pop_front());
            i++;
        end
    endtask

    task automatic release_pulse();
        d_rel = 1;
        @(posedge clk); #1;
        d_rel = 0;
    endtask

    initial begin
        sel = 0; rst = 1; d_addr = '0;
        idle_inputs();
        e_ok = 0; e_bad = 0; e_ovf = 0; e_busy = 0; e_drop = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_avail", 64'(av8), 64'd0);
        chk("rst_len", 64'(len8), 64'd0);
        chk("rst_rd", rd8, 64'd0);
        chk("rst_state", 64'(dut.state_q), 64'(ST_IDLE));
        check_counters("rst");
        rst = 0;
        @(posedge clk); #1;

        // 90-byte frame committed and read back
        send_frame(12, 2, 1, 0, 0, 1, 0, 0, 8'h11, 1);
        e_ok++;
        chk("t1_avail", 64'(av8), 64'd1);
        chk("t1_len", 64'(len8), 64'd90);
        check_counters("t1");
        read_back("t1_rd");
        release_pulse();
        chk("t1_rel", 64'(av8), 64'd0);

        // same frame ending bad, then a fresh frame lands at word 0
        send_frame(12, 2, 1, 0, 0, 0, 1, 0, 8'h21, 0);
        e_bad++;
        chk("t2_avail", 64'(av8), 64'd0);
        chk("t2_state", 64'(dut.state_q), 64'(ST_IDLE));
        check_counters("t2a");
        send_frame(3, 5, 1, 0, 0, 1, 0, 0, 8'h22, 1);
        e_ok++;
        chk("t2_len", 64'(len8), 64'd21);
        check_counters("t2b");
        read_back("t2_rd");
        release_pulse();

        // overflow on the 16-word instance
        sel = 1;
        send_frame(20, 8, 1, 0, 0, 1, 0, 0, 8'h31, 0);
        chk("t3_ovf", 64'(ovf4), 64'd1);
        chk("t3_avail", 64'(av4), 64'd0);
        chk("t3_ok", 64'(ok4), 64'd0);
        chk("t3_state", 64'(dut4.state_q), 64'(ST_IDLE));
        send_frame(2, 3, 1, 0, 0, 1, 0, 0, 8'h32, 1);
        chk("t3_avail2", 64'(av4), 64'd1);
        chk("t3_len", 64'(len4), 64'd11);
        chk("t3_misc", 64'({bd4, busy4} | 64'(drop4)), 64'd0);
        read_back("t3_rd");
        release_pulse();
        sel = 0;
        check_counters("t3");

        // busy refusal, then release coincident with a new frame
        send_frame(5, 6, 1, 0, 0, 1, 0, 0, 8'h41, 1);
        e_ok++;
        chk("t4_len1", 64'(len8), 64'd38);
        send_frame(4, 8, 1, 0, 0, 1, 0, 0, 8'h44, 0);
        e_busy++;
        chk("t4_avail", 64'(av8), 64'd1);
        chk("t4_len2", 64'(len8), 64'd38);
        chk("t4_state", 64'(dut.state_q), 64'(ST_FULL));
        check_counters("t4a");
        read_back("t4_rd1");
        send_frame(3, 1, 1, 0, 0, 1, 0, 1, 8'h45, 1);
        e_ok++;
        chk("t4_avail3", 64'(av8), 64'd1);
        chk("t4_len3", 64'(len8), 64'd17);
        check_counters("t4b");
        read_back("t4_rd3");
        release_pulse();

        // reset in the middle of a capture
        send_frame(3, 8, 1, 0, 0, 0, 0, 0, 8'h51, 0);
        chk("t5_cap", 64'(dut.state_q), 64'(ST_CAPTURE));
        rst = 1;
        @(posedge clk); #1;
        e_ok = 0; e_bad = 0; e_ovf = 0; e_busy = 0; e_drop = 0;
        chk("t5_avail", 64'(av8), 64'd0);
        chk("t5_len", 64'(len8), 64'd0);
        chk("t5_rd", rd8, 64'd0);
        chk("t5_state", 64'(dut.state_q), 64'(ST_IDLE));
        check_counters("t5a");
        rst = 0;
        d_good = 1;
        @(posedge clk); #1;
        d_good = 0;
        chk("t5_avail2", 64'(av8), 64'd0);
        chk("t5_state2", 64'(dut.state_q), 64'(ST_IDLE));
        check_counters("t5b");

        // other, drop, then NTS
        send_frame(3, 8, 0, 1, 0, 1, 0, 0, 8'h61, 0);
        send_frame(3, 8, 0, 0, 1, 1, 0, 0, 8'h62, 0);
        e_drop++;
        chk("t6_avail1", 64'(av8), 64'd0);
        send_frame(4, 4, 1, 0, 0, 1, 0, 0, 8'h63, 1);
        e_ok++;
        chk("t6_avail", 64'(av8), 64'd1);
        chk("t6_len", 64'(len8), 64'd28);
        check_counters("t6");
        read_back("t6_rd");
        release_pulse();

        // lost end marker: new start abandons the partial frame
        send_frame(2, 8, 1, 0, 0, 0, 0, 0, 8'h71, 0);
        send_frame(3, 7, 1, 0, 0, 1, 0, 0, 8'h72, 1);
        e_ok++;
        chk("t7_len", 64'(len8), 64'd23);
        check_counters("t7");
        read_back("t7_rd");
        release_pulse();
        chk("t7_rel", 64'(av8), 64'd0);

        $display("test done: total=%0d bad=%0d", total, nbad);
        $finish;
    end

endmodule

// File: doc/nts_rx_buffer.md
Name: nts_rx_buffer

Overview:
- Sits directly downstream of the RX preprocessor. Consumes its big-endian 64-bit words, 4-bit byte counts and per-frame classification.
- Captures frames classified as NTS into a single-frame buffer and commits a frame only on MAC good-frame. Discards bad, overflowing or unwanted frames.
- Presents a committed frame to the NTS engine through a read port with a release handshake, and keeps statistics counters.

Parameters:
- ADDR_WIDTH, 8, buffer depth is 2^ADDR_WIDTH 64-bit words (default 256 words = 2048 bytes).

Ports:
- i_clk  in  1  clock.
- i_areset  in  1  reset; synchronous, active-high.
- i_rx_data_be  in  64  frame word, big-endian, unused bytes zero.
- i_rx_valid4bit  in  4  valid bytes in i_rx_data_be (0..8).
- i_sof  in  1  first word of frame present this cycle.
- i_packet_nts  in  1  frame is NTS (qualified by i_sof).
- i_packet_other  in  1  frame is not NTS (qualified by i_sof).
- i_packet_drop  in  1  malformed NTP frame (qualified by i_sof).
- i_ethernet_good  in  1  MAC good-frame end marker.
- i_ethernet_bad  in  1  MAC bad-frame end marker.
- i_rd_addr  in  ADDR_WIDTH  engine read word address.
- o_rd_data  out  64  buffer word at i_rd_addr, registered.
- o_packet_available  out  1  committed frame held.
- o_packet_length  out  ADDR_WIDTH+4  committed frame length in bytes.
- i_release  in  1  engine done; frees buffer (pulse).
- o_cnt_nts_ok  out  32  NTS frames committed.
- o_cnt_bad  out  32  NTS frames discarded on i_ethernet_bad.
- o_cnt_overflow  out  32  NTS frames exceeding depth.
- o_cnt_busy  out  32  NTS frames refused because the buffer was full.
- o_cnt_drop  out  32  i_sof with i_packet_drop.

Behaviour:
- Reset:
  - State IDLE.
  - All counters, o_packet_available, o_packet_length and o_rd_data are 0.
  - Write address and byte accumulator are 0.
  - Buffer contents are not cleared.
- States: IDLE, CAPTURE, DISCARD, FULL.
- IDLE:
  - i_sof & i_packet_nts: write word 0 if i_rx_valid4bit != 0, set byte accumulator = i_rx_valid4bit, go to CAPTURE.
  - i_sof & !i_packet_nts: go to DISCARD.
  - Good/bad markers without a frame are ignored.
- CAPTURE:
  - Each cycle with i_rx_valid4bit != 0: write word at the write address, increment address, add i_rx_valid4bit to the accumulator. The word present in the cycle the end marker arrives is written first.
  - i_ethernet_good: latch o_packet_length = accumulator (including that cycle), assert o_packet_available next cycle, increment o_cnt_nts_ok, go to FULL.
  - i_ethernet_bad (takes priority if both markers are set): increment o_cnt_bad, go to IDLE.
  - Word needing write address 2^ADDR_WIDTH: increment o_cnt_overflow, go to DISCARD.
  - i_sof mid-capture (lost end marker): abandon the current frame with no counter change and restart per IDLE rules in the same cycle.
- DISCARD:
  - Ignore data until i_ethernet_good or i_ethernet_bad, then go to IDLE.
  - i_sof restarts per IDLE rules.
- FULL:
  - Buffer is read-only. i_sof & i_packet_nts increments o_cnt_busy and the frame is ignored.
  - i_release: clear o_packet_available next cycle. If i_sof & i_packet_nts in the same cycle, go directly to CAPTURE and write word 0; else go to IDLE.
  - i_release outside FULL is ignored.
- o_cnt_drop increments on i_sof & i_packet_drop in any state.
- All counters wrap at 2^32.
- Read port:
  - One-cycle latency, valid in all states.
  - Data is meaningful only while o_packet_available.
  - Reading a word beyond the frame returns stale data.
- Length arithmetic: the accumulator is ADDR_WIDTH+4 bits; maximum value 8*2^ADDR_WIDTH.
- Write addresses are contiguous from 0 per frame; there is no wrap-around.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=0, CAPTURE=1, DISCARD=2, FULL=3);
  - counter width 32;
  - BYTES_PER_WORD = 8.
- One sub-module, nts_rx_bram: simple dual-port RAM (1 write, 1 registered read, depth 2^ADDR_WIDTH x 64) for block-RAM inference.

Test Plan:
- 90-byte NTS frame (11 words of 8 bytes + 1 word of 2 bytes, good on last word) -> o_packet_available=1, o_packet_length=90, words 0..11 read back exactly, o_cnt_nts_ok=1.
- Same frame ending with i_ethernet_bad -> o_packet_available stays 0, o_cnt_bad=1, next NTS frame accepted at address 0.
- ADDR_WIDTH=4, 20-word NTS frame -> o_cnt_overflow=1, no commit, state IDLE after end marker.
- Frame committed, second NTS frame arrives before release -> o_cnt_busy=1, buffer contents and o_packet_length unchanged. Then i_release coincident with a third i_sof & i_packet_nts -> third frame captured and committed.
- Reset asserted mid-CAPTURE -> all outputs 0, state IDLE; good marker after reset ignored, o_cnt_nts_ok=0.
- Interleaved i_packet_other frame, then i_packet_drop frame, then NTS frame -> o_cnt_drop=1, only the NTS frame is committed.
